// File: rtl/cellrv32_uart_tx_engine_pkg.sv
// Shared types and helpers for the cellrv32 UART transmit engine.
package cellrv32_uart_tx_engine_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } uart_tx_state_t;

    // Number of bits needed to index n items (ceil(log2(n))).
    function automatic int index_size_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cellrv32_uart_tx_engine_if.sv
// FIFO read port as seen by the UART TX engine (async-read FIFO).
interface cellrv32_uart_tx_engine_if #(
    parameter int DATA_BITS = 8
);
    logic                 avail;
    logic [DATA_BITS-1:0] rdata;
    logic                 re;

    modport master (input avail, input rdata, output re);
    modport slave  (output avail, output rdata, input re);
endinterface

// File: rtl/cellrv32_uart_tx_engine_sync2ff.sv
// Two-flop synchronizer with selectable reset value.
module cellrv32_sync2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= {2{RST_VAL}};
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];
endmodule

// File: rtl/cellrv32_uart_tx_engine.sv
// UART transmitter: pops bytes from an async-read FIFO and serializes them
// (start, LSB-first data, optional parity, stop) with CTS flow control.
module cellrv32_uart_tx_engine
    import cellrv32_uart_tx_engine_pkg::*;
#(
    parameter int   DATA_BITS  = 8,
    parameter int   BAUD_W     = 12,
    parameter logic PARITY_EN  = 1'b0,
    parameter logic PARITY_ODD = 1'b0,
    parameter int   STOP_BITS  = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  en_i,
    input  logic [BAUD_W-1:0]     baud_div_i,
    input  logic                  cts_n_i,
    cellrv32_uart_tx_engine_if.master fifo_if,
    output logic                  txd_o,
    output logic                  busy_o,
    output logic                  done_o
);
    localparam int BCW = index_size_f(DATA_BITS) + 1;

    uart_tx_state_t       state_q, state_d;
    logic [BCW-1:0]       bitcnt_q, bitcnt_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BAUD_W-1:0]    div_q, div_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_q, par_d;
    logic                 txd_q, txd_d;
    logic                 busy_q, busy_d;

    logic cts_n_s, cts_ok, bit_end, last_stop, pop;

    cellrv32_sync2ff #(.RST_VAL(1'b1)) u_cts_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cts_n_i),
        .q_o   (cts_n_s)
    );

    assign cts_ok    = ~cts_n_s;
    assign bit_end   = (baud_q == '0);
    assign last_stop = (state_q == TX_STOP) && bit_end && (bitcnt_q == BCW'(STOP_BITS - 1));
    // A new frame may start straight out of the final stop-bit cycle, giving gapless back-to-back frames.
    assign pop       = en_i & fifo_if.avail & cts_ok & ~clear_i &
                       ((state_q == TX_IDLE) | last_stop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= TX_IDLE;
            bitcnt_q <= '0;
            baud_q   <= '0;
            div_q    <= '0;
            shreg_q  <= '0;
            par_q    <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            baud_q   <= baud_d;
            div_q    <= div_d;
            shreg_q  <= shreg_d;
            par_q    <= par_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        baud_d   = baud_q;
        div_d    = div_q;
        shreg_d  = shreg_q;
        par_d    = par_q;
        if (clear_i) begin
            state_d  = TX_IDLE;
            bitcnt_d = '0;
            baud_d   = '0;
        end else if (pop) begin
            state_d  = TX_START;
            bitcnt_d = '0;
            shreg_d  = fifo_if.rdata;
            div_d    = baud_div_i;
            baud_d   = baud_div_i;
            par_d    = (^fifo_if.rdata) ^ PARITY_ODD;
        end else if (state_q != TX_IDLE) begin
            if (!bit_end) begin
                baud_d = baud_q - BAUD_W'(1);
            end else begin
                baud_d = div_q;
                case (state_q)
                    TX_START: begin
                        state_d  = TX_DATA;
                        bitcnt_d = '0;
                    end
                    TX_DATA: begin
                        if (bitcnt_q == BCW'(DATA_BITS - 1)) begin
                            bitcnt_d = '0;
                            state_d  = PARITY_EN ? TX_PARITY : TX_STOP;
                        end else begin
                            bitcnt_d = bitcnt_q + BCW'(1);
                            shreg_d  = shreg_q >> 1;
                        end
                    end
                    TX_PARITY: begin
                        state_d  = TX_STOP;
                        bitcnt_d = '0;
                    end
                    TX_STOP: begin
                        if (bitcnt_q == BCW'(STOP_BITS - 1)) begin
                            state_d  = TX_IDLE;
                            bitcnt_d = '0;
                            baud_d   = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + BCW'(1);
                        end
                    end
                    default: state_d = TX_IDLE;
                endcase
            end
        end
    end

    // Line level is derived from the next state so txd_o lines up with state_q.
    always_comb begin
        txd_d = 1'b1;
        case (state_d)
            TX_START:  txd_d = 1'b0;
            TX_DATA:   txd_d = shreg_d[0];
            TX_PARITY: txd_d = par_d;
            default:   txd_d = 1'b1;
        endcase
        busy_d     = (state_d != TX_IDLE);
        fifo_if.re = pop;
        done_o     = last_stop & ~clear_i;
    end

    assign txd_o  = txd_q;
    assign busy_o = busy_q;
endmodule

// File: tb/tb_cellrv32_uart_tx_engine.sv
// Directed bench for cellrv32_uart_tx_engine: framing, back-to-back, CTS, parity, clear, reset.
module tb_cellrv32_uart_tx_engine;
    logic        clk = 1'b0;
    logic        rst, clear, en, cts_n;
    logic [11:0] baud_div;

    logic s_txd [3];
    logic s_busy[3];
    logic s_done[3];
    logic s_re  [3];

    logic [7:0] mem [3][16];
    logic [3:0] wp  [3] = '{default: 4'd0};
    logic [3:0] rp  [3] = '{default: 4'd0};

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    cellrv32_uart_tx_engine_if #(.DATA_BITS(8)) f0 ();
    cellrv32_uart_tx_engine_if #(.DATA_BITS(8)) f1 ();
    cellrv32_uart_tx_engine_if #(.DATA_BITS(8)) f2 ();

    assign f0.avail = (wp[0] != rp[0]);
    assign f0.rdata = mem[0][rp[0]];
    assign s_re[0]  = f0.re;
    assign f1.avail = (wp[1] != rp[1]);
    assign f1.rdata = mem[1][rp[1]];
    assign s_re[1]  = f1.re;
    assign f2.avail = (wp[2] != rp[2]);
    assign f2.rdata = mem[2][rp[2]];
    assign s_re[2]  = f2.re;

    cellrv32_uart_tx_engine u_dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en), .baud_div_i(baud_div),
        .cts_n_i(cts_n), .fifo_if(f0), .txd_o(s_txd[0]), .busy_o(s_busy[0]), .done_o(s_done[0]));

    cellrv32_uart_tx_engine #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_po (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en), .baud_div_i(baud_div),
        .cts_n_i(cts_n), .fifo_if(f1), .txd_o(s_txd[1]), .busy_o(s_busy[1]), .done_o(s_done[1]));

    cellrv32_uart_tx_engine #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_pe (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .en_i(en), .baud_div_i(baud_div),
        .cts_n_i(cts_n), .fifo_if(f2), .txd_o(s_txd[2]), .busy_o(s_busy[2]), .done_o(s_done[2]));

    // FIFO model read side: pop on re at the clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (s_re[i] && (wp[i] != rp[i])) rp[i] <= rp[i] + 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int sel, input logic [7:0] d);
        mem[sel][wp[sel]] = d;
        wp[sel] = wp[sel] + 4'd1;
    endtask

    function automatic logic [15:0] mk(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    function automatic logic [15:0] mkp(input logic [7:0] d, input logic p);
        return {5'b0, 1'b1, p, d, 1'b0};
    endfunction

    task automatic wait_re(input int sel, input string tag);
        logic found;
        found = 1'b0;
        #1;
        for (int k = 0; k < 50; k++) begin
            if (s_re[sel]) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk({tag, "_re_seen"}, found, 1'b1);
    endtask

    task automatic frame_check(input string tag, input int sel, input logic [15:0] bits,
                               input int nbits, input int per, input logic next_pop);
        logic last;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < per; c++) begin
                @(negedge clk);
                last = (b == nbits - 1) && (c == per - 1);
                chk($sformatf("%s_txd_b%0d_c%0d", tag, b, c), s_txd[sel], bits[b]);
                chk($sformatf("%s_busy_b%0d_c%0d", tag, b, c), s_busy[sel], 1'b1);
                chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), s_done[sel], last);
                chk($sformatf("%s_re_b%0d_c%0d", tag, b, c), s_re[sel], next_pop & last);
            end
        end
    endtask

    initial begin
        int lat;
        int re_cnt;
        rst      = 1'b1;
        clear    = 1'b0;
        en       = 1'b0;
        cts_n    = 1'b1;
        baud_div = 12'd0;
        #2;
        chk("rst_txd",  s_txd[0],  1'b1);
        chk("rst_busy", s_busy[0], 1'b0);
        chk("rst_done", s_done[0], 1'b0);
        chk("rst_re",   s_re[0],   1'b0);
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        en       = 1'b1;
        cts_n    = 1'b0;
        baud_div = 12'd3;
        repeat (3) @(negedge clk);

        // 1) 8N1, div=3, 0xA5
        push(0, 8'hA5);
        wait_re(0, "t1");
        frame_check("t1", 0, mk(8'hA5), 10, 4, 1'b0);
        @(negedge clk);
        chk("t1_idle_busy", s_busy[0], 1'b0);
        chk("t1_idle_txd",  s_txd[0],  1'b1);
        chk("t1_pops",      rp[0],     4'd1);

        // 2) back-to-back 0x00, 0xFF at div=0
        baud_div = 12'd0;
        push(0, 8'h00);
        push(0, 8'hFF);
        wait_re(0, "t2");
        frame_check("t2a", 0, mk(8'h00), 10, 1, 1'b1);
        frame_check("t2b", 0, mk(8'hFF), 10, 1, 1'b0);
        @(negedge clk);
        chk("t2_idle_busy", s_busy[0], 1'b0);
        chk("t2_pops",      rp[0],     4'd3);

        // 3) CTS flow control
        cts_n    = 1'b1;
        baud_div = 12'd1;
        repeat (3) @(negedge clk);
        push(0, 8'h3C);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("t3_hold_re_%0d", k),  s_re[0],  1'b0);
            chk($sformatf("t3_hold_txd_%0d", k), s_txd[0], 1'b1);
        end
        cts_n = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (s_re[0]) begin
                lat = k;
                break;
            end
        end
        chk("t3_cts_latency_ok", (lat >= 2 && lat <= 3), 1'b1);
        frame_check("t3", 0, mk(8'h3C), 10, 2, 1'b0);

        // 4) parity odd then even, 0x07, div=1
        push(1, 8'h07);
        wait_re(1, "t4o");
        frame_check("t4o", 1, mkp(8'h07, 1'b0), 11, 2, 1'b0);
        push(2, 8'h07);
        wait_re(2, "t4e");
        frame_check("t4e", 2, mkp(8'h07, 1'b1), 11, 2, 1'b0);

        // 5) clear during data bit 3
        baud_div = 12'd3;
        push(0, 8'h5A);
        push(0, 8'h81);
        wait_re(0, "t5");
        repeat (17) @(negedge clk);
        chk("t5_pre_txd_bit3", s_txd[0], 1'b1);
        clear = 1'b1;
        #1;
        chk("t5_clr_re",   s_re[0],   1'b0);
        chk("t5_clr_done", s_done[0], 1'b0);
        @(negedge clk);
        chk("t5_after_txd",  s_txd[0],  1'b1);
        chk("t5_after_busy", s_busy[0], 1'b0);
        chk("t5_after_done", s_done[0], 1'b0);
        clear = 1'b0;
        #1;
        chk("t5_level", 32'(wp[0] - rp[0]), 1);
        chk("t5_repop", s_re[0], 1'b1);
        frame_check("t5", 0, mk(8'h81), 10, 4, 1'b0);

        // 6) async reset mid-stop, then no pops from an empty FIFO
        push(0, 8'hC3);
        wait_re(0, "t6");
        repeat (37) @(negedge clk);
        chk("t6_pre_busy", s_busy[0], 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_txd",  s_txd[0],  1'b1);
        chk("t6_rst_busy", s_busy[0], 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        re_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (s_re[0]) re_cnt++;
        end
        chk("t6_no_re",   re_cnt,    0);
        chk("t6_txd_idle", s_txd[0], 1'b1);
        chk("t6_busy_idle", s_busy[0], 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
